// File: rtl/comp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comp_pkg
// Description : Shared mode encodings, FSM state type and helpers for the
//               iterative two's-complement pass/negate/abs unit.
// Revision    : 1.0 - initial release
// ============================================================================
package comp_pkg;

    // Operation select; the fourth code is treated as a second negate.
    localparam logic [1:0] MODE_PASS    = 2'b00;
    localparam logic [1:0] MODE_NEG     = 2'b01;
    localparam logic [1:0] MODE_ABS     = 2'b10;
    localparam logic [1:0] MODE_NEG_ALT = 2'b11;

    // Control states of the iterative unit.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Decide whether the operand must be inverted-and-incremented for this
    // mode. Abs only inverts when the operand sign bit is set.
    function automatic logic mode_inverts(input logic [1:0] mode, input logic sign);
        logic inv;
        inv = 1'b0;
        case (mode)
            MODE_NEG,
            MODE_NEG_ALT: inv = 1'b1;
            MODE_ABS:     inv = sign;
            default:      inv = 1'b0;
        endcase
        return inv;
    endfunction

endpackage : comp_pkg
`default_nettype wire

// File: rtl/comp_chunk.sv
`default_nettype none
// ============================================================================
// Module      : comp_chunk
// Description : Combinational CHUNK-bit slice computing
//               {cout, sum} = (inv ? ~chunk : chunk) + cin.
// Revision    : 1.0 - initial release
// ============================================================================
module comp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] chunk,
    input  logic             inv,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK-1:0] w_operand;
    logic [CHUNK:0]   w_total;

    // Conditional one's complement followed by the incoming carry.
    always_comb begin
        w_operand = inv ? ~chunk : chunk;
        w_total   = {1'b0, w_operand} + {{CHUNK{1'b0}}, cin};
    end

    assign sum  = w_total[CHUNK-1:0];
    assign cout = w_total[CHUNK];

endmodule : comp_chunk
`default_nettype wire

// File: rtl/comp_iter.sv
`default_nettype none
// ============================================================================
// Module      : comp_iter
// Description : Iterative pass / negate / abs unit. Processes CHUNK bits per
//               cycle with a registered carry between chunks, valid/ready on
//               both sides, and flags non-representable results.
// Revision    : 1.0 - initial release
// ============================================================================
module comp_iter
    import comp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0]    K_LAST   = KW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Reject configurations where the operand does not split into whole chunks.
    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("comp_iter: WIDTH must be an exact multiple of CHUNK");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_result;
    logic [KW-1:0]    r_k;
    logic             r_carry;
    logic             r_inv;
    logic             r_ovf;
    logic             r_out_valid;

    logic             w_in_ready;
    logic             w_step;
    logic             w_accept;
    logic             w_inv_in;
    logic             w_last;
    int               w_base;
    logic [CHUNK-1:0] w_chunk_in;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;

    assign w_accept = in_valid && w_in_ready;
    assign w_inv_in = mode_inverts(in_mode, in_data[WIDTH-1]);
    assign w_last   = (r_k == K_LAST);

    // Select the chunk of the latched operand addressed by the counter.
    always_comb begin
        w_base     = int'(r_k) * CHUNK;
        w_chunk_in = r_operand[w_base +: CHUNK];
    end

    // Single slice reused every BUSY cycle.
    comp_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .chunk (w_chunk_in),
        .inv   (r_inv),
        .cin   (r_carry),
        .sum   (w_sum),
        .cout  (w_cout)
    );

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; DONE can hand straight over to a new operand.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = in_valid ? ST_BUSY : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs; in_ready depends on out_ready only, never on in_valid.
    always_comb begin
        w_in_ready = 1'b0;
        w_step     = 1'b0;
        case (r_state)
            ST_IDLE: w_in_ready = 1'b1;
            ST_BUSY: w_step     = 1'b1;
            ST_DONE: w_in_ready = out_ready;
            default: w_in_ready = 1'b0;
        endcase
    end

    // Operand capture at acceptance, then one chunk of result per BUSY cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_operand <= '0;
            r_result  <= '0;
            r_k       <= '0;
            r_carry   <= 1'b0;
            r_inv     <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_operand <= in_data;
            r_inv     <= w_inv_in;
            r_carry   <= w_inv_in;
            r_ovf     <= w_inv_in && (in_data == MOST_NEG);
            r_k       <= '0;
        end else if (w_step) begin
            r_result[w_base +: CHUNK] <= w_sum;
            r_carry                   <= w_cout;
            r_k                       <= w_last ? '0 : r_k + KW'(1);
        end
    end

    // Registered result-valid flag tracking entry into DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (w_state_next == ST_DONE);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_result;
    assign out_ovf   = r_ovf;

endmodule : comp_iter
`default_nettype wire

// File: tb/tb_comp_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_comp_iter
// Description : Self-checking bench for comp_iter at CHUNK = 8, 32 and 1,
//               using an integer-arithmetic reference model.
// Revision    : 1.1 - checking task and expired-wait check
// ============================================================================
module tb_comp_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ovf;
    logic [31:0] in_data  [3];
    logic [1:0]  in_mode  [3];
    logic [31:0] out_data [3];

    int n_assert = 0;
    int n_fail   = 0;

    // Unit 0: CHUNK 8, unit 1: CHUNK 32, unit 2: CHUNK 1.
    comp_iter #(.WIDTH(32), .CHUNK(8)) u_c8 (
        .clock(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_mode(in_mode[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_ovf(out_ovf[0])
    );
    comp_iter #(.WIDTH(32), .CHUNK(32)) u_c32 (
        .clock(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_mode(in_mode[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_ovf(out_ovf[1])
    );
    comp_iter #(.WIDTH(32), .CHUNK(1)) u_c1 (
        .clock(clk), .reset(reset),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_mode(in_mode[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .out_ovf(out_ovf[2])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed integer value, optionally negated; overflow when the
    // true result exceeds the largest 32-bit signed value.
    task automatic model(input logic [31:0] x, input logic [1:0] m,
                         output logic [31:0] r, output logic o);
        longint v;
        longint res;
        bit     neg;
        v   = longint'($signed(x));
        neg = (m != 2'b00) && !(m == 2'b10 && v >= 0);
        res = neg ? -v : v;
        r   = res[31:0];
        o   = (res > 64'sd2147483647);
    endtask

    // Called at the first falling edge after acceptance; waits for the result.
    task automatic wait_result(input int u, input logic [31:0] d, input logic [1:0] m,
                               input int lat, input string tag);
        int          cyc;
        logic [31:0] er;
        logic        eo;
        model(d, m, er, eo);
        cyc = 0;
        while (!out_valid[u] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_assert++;
        if (!out_valid[u]) begin
            n_fail++;
            $error("FAIL %s: timed out waiting for out_valid after %0d cycles", tag, cyc);
        end
        check({tag, " latency"}, cyc, lat);
        check({tag, " data"}, out_data[u], er);
        check({tag, " ovf"}, out_ovf[u], eo);
    endtask

    // Offer one operand, scramble mode/data after acceptance, await result.
    task automatic launch(input int u, input logic [31:0] d, input logic [1:0] m,
                          input int lat, input string tag);
        @(negedge clk);
        check({tag, " in_ready"}, in_ready[u], 1'b1);
        in_valid[u] = 1'b1;
        in_data[u]  = d;
        in_mode[u]  = m;
        @(negedge clk);
        in_valid[u] = 1'b0;
        in_mode[u]  = ~m;
        in_data[u]  = $urandom;
        wait_result(u, d, m, lat, tag);
    endtask

    task automatic consume(input int u, input string tag);
        out_ready[u] = 1'b1;
        @(negedge clk);
        out_ready[u] = 1'b0;
        check({tag, " drained"}, out_valid[u], 1'b0);
    endtask

    task automatic do_op(input int u, input logic [31:0] d, input logic [1:0] m,
                         input int lat, input string tag);
        launch(u, d, m, lat, tag);
        consume(u, tag);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] held;
        logic [1:0]  m;
        logic [31:0] er;
        logic        eo;

        reset     = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        for (int i = 0; i < 3; i++) begin
            in_data[i] = '0;
            in_mode[i] = '0;
        end

        // Reset state on all three configurations.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset out_valid", out_valid[i], 1'b0);
            check("reset out_data", out_data[i], 32'h0);
            check("reset out_ovf", out_ovf[i], 1'b0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("idle in_ready", in_ready, 3'b111);

        // Directed operands on CHUNK 8.
        do_op(0, 32'h0000_0001, 2'b01, 4, "neg 1");
        do_op(0, 32'h8000_0000, 2'b01, 4, "neg mostneg");
        do_op(0, 32'h8000_0000, 2'b10, 4, "abs mostneg");
        do_op(0, 32'hFFFF_FF9C, 2'b10, 4, "abs neg");
        do_op(0, 32'h0000_0064, 2'b10, 4, "abs pos");
        do_op(0, 32'hDEAD_BEEF, 2'b00, 4, "pass");
        do_op(0, 32'h0000_0000, 2'b01, 4, "neg 0");
        do_op(0, 32'h0000_0005, 2'b11, 4, "mode 11");

        // Random operands, with boundary values mixed in.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 5))
                0:       d = 32'h8000_0000;
                1:       d = 32'h7FFF_FFFF;
                2:       d = 32'hFFFF_FFFF;
                default: d = $urandom;
            endcase
            m = 2'($urandom_range(0, 3));
            do_op(0, d, m, 4, "rand c8");
        end

        // Back-pressure: result held stable and in_ready low while stalled.
        launch(0, 32'h0000_1234, 2'b01, 4, "stall");
        model(32'h0000_1234, 2'b01, er, eo);
        repeat (5) begin
            @(negedge clk);
            check("stall out_valid", out_valid[0], 1'b1);
            check("stall data", out_data[0], er);
            check("stall ovf", out_ovf[0], eo);
            check("stall in_ready", in_ready[0], 1'b0);
        end
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_data[0]   = 32'h8000_0000;
        in_mode[0]   = 2'b10;
        #1;
        check("b2b in_ready", in_ready[0], 1'b1);
        @(negedge clk);
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b0;
        in_mode[0]   = 2'b00;
        check("b2b busy", out_valid[0], 1'b0);
        wait_result(0, 32'h8000_0000, 2'b10, 4, "b2b");
        held = out_data[0];

        // Reset while a result is held in DONE.
        reset = 1'b1;
        #1;
        check("rst done out_valid", out_valid[0], 1'b0);
        check("rst done data", out_data[0], 32'h0);
        check("rst done ovf", out_ovf[0], 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Reset in BUSY with two chunks already written.
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = 32'h1234_5678;
        in_mode[0]  = 2'b01;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst busy out_valid", out_valid[0], 1'b0);
        check("rst busy data", out_data[0], 32'h0);
        check("rst busy ovf", out_ovf[0], 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst release in_ready", in_ready[0], 1'b1);
        repeat (6) @(negedge clk);
        check("rst discarded", out_valid[0], 1'b0);
        do_op(0, 32'h0000_0001, 2'b01, 4, "after rst");

        // CHUNK 32 (latency 1) and CHUNK 1 (latency 32).
        do_op(1, 32'h0000_0001, 2'b01, 1, "c32 neg 1");
        do_op(1, 32'h8000_0000, 2'b10, 1, "c32 abs mostneg");
        do_op(2, 32'h0000_0001, 2'b01, 32, "c1 neg 1");
        do_op(2, 32'h0000_0000, 2'b01, 32, "c1 neg 0");
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            m = 2'($urandom_range(0, 3));
            do_op(1, d, m, 1, "rand c32");
            do_op(2, d, m, 32, "rand c1");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_comp_iter
`default_nettype wire
